// File: rtl/dram_pkg.sv
// Shared widths, defaults and FSM encoding for the DRAM arbiter slice.
// Imported by the arbiter top and its round-robin picker.
package dram_pkg;

    localparam int ADDR_W          = 9;
    localparam int DATA_W          = 16;
    localparam int N_CORES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDWAIT,
        DONE
    } state_t;

    // Rotating search position: (base + offset) wrapped into 0..n-1
    function automatic int wrapIdx(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requesting core found when
// searching upward from the pointer, wrapping at N_CORES.
module rr_picker
    import dram_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEFAULT,
    localparam int PTR_W = $clog2(N_CORES)
) (
    input  logic [N_CORES-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rrPtr,
    output logic               o_valid,
    output logic [PTR_W-1:0]   o_winner
);

    logic [PTR_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_idx    = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            w_idx = PTR_W'(wrapIdx(int'(i_rrPtr), k, N_CORES));
            if (i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter giving N_CORES requesters turns at one 512x16
// single-port RAM; every output comes straight from a register.
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEFAULT,
    localparam int PTR_W = $clog2(N_CORES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CORES-1:0]        req,
    input  logic [N_CORES-1:0]        we,
    input  logic [N_CORES*ADDR_W-1:0] addr,
    input  logic [N_CORES*DATA_W-1:0] wdata,
    output logic [N_CORES-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      ram_write_en,
    output logic                      ram_read_en,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
);

    state_t               r_state;
    logic [PTR_W-1:0]     r_rrPtr;
    logic [PTR_W-1:0]     r_winner;
    logic [N_CORES-1:0]   r_ack;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_busy;
    logic                 r_ramWriteEn;
    logic                 r_ramReadEn;
    logic [ADDR_W-1:0]    r_ramAddr;
    logic [DATA_W-1:0]    r_ramWdata;

    logic                 w_pickValid;
    logic [PTR_W-1:0]     w_pickWinner;

    rr_picker #(
        .N_CORES (N_CORES)
    ) u_picker (
        .i_req    (req),
        .i_rrPtr  (r_rrPtr),
        .o_valid  (w_pickValid),
        .o_winner (w_pickWinner)
    );

    // IDLE -> ACCESS -> (RDWAIT for reads) -> DONE -> IDLE; requests are
    // only looked at in IDLE, so anything arriving mid-access simply waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rrPtr      <= '0;
            r_winner     <= '0;
            r_ack        <= '0;
            r_rdata      <= '0;
            r_busy       <= 1'b0;
            r_ramWriteEn <= 1'b0;
            r_ramReadEn  <= 1'b0;
            r_ramAddr    <= '0;
            r_ramWdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= '0;
                    if (w_pickValid) begin
                        r_winner     <= w_pickWinner;
                        r_rrPtr      <= PTR_W'(wrapIdx(int'(w_pickWinner), 1, N_CORES));
                        r_ramAddr    <= addr[int'(w_pickWinner)*ADDR_W +: ADDR_W];
                        r_ramWdata   <= wdata[int'(w_pickWinner)*DATA_W +: DATA_W];
                        r_ramWriteEn <= we[w_pickWinner];
                        r_ramReadEn  <= ~we[w_pickWinner];
                        r_busy       <= 1'b1;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // RAM samples the enables on this edge; the write flag picks the path
                    r_ramWriteEn <= 1'b0;
                    r_ramReadEn  <= 1'b0;
                    if (r_ramWriteEn) begin
                        r_ack   <= N_CORES'(1) << r_winner;
                        r_state <= DONE;
                    end else begin
                        r_state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    r_rdata <= ram_rdata;
                    r_ack   <= N_CORES'(1) << r_winner;
                    r_state <= DONE;
                end
                DONE: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack          = r_ack;
    assign rdata        = r_rdata;
    assign busy         = r_busy;
    assign ram_write_en = r_ramWriteEn;
    assign ram_read_en  = r_ramReadEn;
    assign ram_addr     = r_ramAddr;
    assign ram_wdata    = r_ramWdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with four cores and a behavioural
// 512x16 RAM that returns read data the cycle after the read enable.
module tb_dram_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [35:0] addr;
    logic [63:0] wdata;
    logic [3:0]  ack;
    logic [15:0] rdata;
    logic        busy;
    logic        ram_write_en;
    logic        ram_read_en;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] mem [512];

    int nVectors;
    int nMiscompares;

    dram_arbiter #(
        .N_CORES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ack          (ack),
        .rdata        (rdata),
        .busy         (busy),
        .ram_write_en (ram_write_en),
        .ram_read_en  (ram_read_en),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr] <= ram_wdata;
        if (ram_read_en)  ram_rdata <= mem[ram_addr];
    end

    // Enables must be exclusive and at most one ack bit may be high, every cycle
    always @(negedge clk) begin
        if (!rst) begin
            nVectors++;
            if (ram_write_en && ram_read_en) begin
                nMiscompares++;
                $display("[TB] FAIL enable_exclusive got we=%b re=%b expected not both", ram_write_en, ram_read_en);
            end
            nVectors++;
            if ($countones(ack) > 1) begin
                nMiscompares++;
                $display("[TB] FAIL ack_onehot got %b expected at most one bit", ack);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int c, input bit w, input logic [8:0] a, input logic [15:0] d);
        we[c]             = w;
        addr[c*9 +: 9]    = a;
        wdata[c*16 +: 16] = d;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Ticks until any ack appears (bounded); returns 0 if none arrived
    task automatic wait_ack(output logic [3:0] ackObs, output logic [15:0] rdObs, output int lat);
        ackObs = '0;
        rdObs  = '0;
        lat    = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            lat++;
            if (ack !== 4'b0000) begin
                ackObs = ack;
                rdObs  = rdata;
                break;
            end
        end
    endtask

    // One complete access from a lone core, returning to IDLE afterwards
    task automatic do_access(input int c, input bit w, input logic [8:0] a, input logic [15:0] d,
                             output logic [3:0] ackObs, output logic [15:0] rdObs, output int lat);
        set_core(c, w, a, d);
        req[c] = 1'b1;
        wait_ack(ackObs, rdObs, lat);
        req[c] = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        tick();
        tick();
        nVectors++;
        if (ack !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL rst_ack got %b expected 0000", ack); end
        nVectors++;
        if (rdata !== 16'h0000) begin nMiscompares++; $display("[TB] FAIL rst_rdata got %h expected 0000", rdata); end
        nVectors++;
        if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_busy got %b expected 0", busy); end
        nVectors++;
        if (ram_write_en !== 1'b0 || ram_read_en !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL rst_enables got %b%b expected 00", ram_write_en, ram_read_en);
        end
        nVectors++;
        if (ram_addr !== 9'h000) begin nMiscompares++; $display("[TB] FAIL rst_ram_addr got %h expected 000", ram_addr); end
        nVectors++;
        if (ram_wdata !== 16'h0000) begin nMiscompares++; $display("[TB] FAIL rst_ram_wdata got %h expected 0000", ram_wdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read;
        logic [3:0]  a;
        logic [15:0] d;
        int          lat;
        set_core(2, 1'b1, 9'h1A5, 16'hBEEF);
        req[2] = 1'b1;
        tick();
        nVectors++;
        if (ram_write_en !== 1'b1 || ram_read_en !== 1'b0 || busy !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL wr_access_ctrl got we=%b re=%b busy=%b expected 1 0 1", ram_write_en, ram_read_en, busy);
        end
        nVectors++;
        if (ram_addr !== 9'h1A5 || ram_wdata !== 16'hBEEF) begin
            nMiscompares++;
            $display("[TB] FAIL wr_access_bus got %h/%h expected 1a5/beef", ram_addr, ram_wdata);
        end
        nVectors++;
        if (ack !== 4'b0000) begin nMiscompares++; $display("[TB] FAIL wr_early_ack got %b expected 0000", ack); end
        tick();
        nVectors++;
        if (ack !== 4'b0100) begin nMiscompares++; $display("[TB] FAIL wr_ack_at_2 got %b expected 0100", ack); end
        req[2] = 1'b0;
        tick();
        nVectors++;
        if (busy !== 1'b0 || ack !== 4'b0000) begin
            nMiscompares++;
            $display("[TB] FAIL wr_back_idle got busy=%b ack=%b expected 0 0000", busy, ack);
        end

        do_access(2, 1'b0, 9'h1A5, 16'h0000, a, d, lat);
        nVectors++;
        if (a !== 4'b0100) begin nMiscompares++; $display("[TB] FAIL rd_ack got %b expected 0100", a); end
        nVectors++;
        if (lat != 3) begin nMiscompares++; $display("[TB] FAIL rd_latency got %0d expected 3", lat); end
        nVectors++;
        if (d !== 16'hBEEF) begin nMiscompares++; $display("[TB] FAIL rd_data got %h expected beef", d); end
    endtask

    task automatic test_round_robin;
        logic [3:0]  a;
        logic [15:0] d;
        int          lat;
        int          expOrder [5] = '{0, 1, 2, 3, 0};
        logic [3:0]  expAck;
        apply_reset();
        for (int c = 0; c < 4; c++) set_core(c, 1'b1, 9'(9'h040 + c), 16'(16'h1000 + c));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(a, d, lat);
            expAck = 4'b0001 << expOrder[k];
            nVectors++;
            if (a !== expAck) begin
                nMiscompares++;
                $display("[TB] FAIL rr_grant_%0d got %b expected %b", k, a, expAck);
            end
            if (k == 0) begin
                nVectors++;
                if (lat != 2) begin nMiscompares++; $display("[TB] FAIL rr_first_latency got %0d expected 2", lat); end
            end
            if (expOrder[k] != 0 || k == 4) req[expOrder[k]] = 1'b0;
        end
        tick();
        nVectors++;
        if (mem[9'h042] !== 16'h1002) begin
            nMiscompares++;
            $display("[TB] FAIL rr_core2_mem got %h expected 1002", mem[9'h042]);
        end
    endtask

    task automatic test_wrap;
        logic [3:0]  a;
        logic [15:0] d;
        int          lat;
        do_access(3, 1'b1, 9'h0F0, 16'h3333, a, d, lat);
        nVectors++;
        if (a !== 4'b1000) begin nMiscompares++; $display("[TB] FAIL wrap_core3 got %b expected 1000", a); end
        set_core(0, 1'b1, 9'h0F1, 16'h0A0A);
        set_core(3, 1'b1, 9'h0F2, 16'h3A3A);
        req = 4'b1001;
        wait_ack(a, d, lat);
        nVectors++;
        if (a !== 4'b0001) begin nMiscompares++; $display("[TB] FAIL wrap_first got %b expected 0001", a); end
        req[0] = 1'b0;
        wait_ack(a, d, lat);
        nVectors++;
        if (a !== 4'b1000) begin nMiscompares++; $display("[TB] FAIL wrap_second got %b expected 1000", a); end
        req[3] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access;
        logic [3:0]  a;
        logic [15:0] d;
        int          lat;
        set_core(2, 1'b0, 9'h1A5, 16'h0000);
        req[2] = 1'b1;
        tick();
        nVectors++;
        if (ram_read_en !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rstmid_in_access got %b expected 1", ram_read_en); end
        #2 rst = 1'b1;
        #1;
        nVectors++;
        if (ack !== 4'b0000 || busy !== 1'b0 || ram_read_en !== 1'b0 || ram_write_en !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL rstmid_ctrl got ack=%b busy=%b re=%b we=%b expected all 0", ack, busy, ram_read_en, ram_write_en);
        end
        nVectors++;
        if (ram_addr !== 9'h000 || rdata !== 16'h0000) begin
            nMiscompares++;
            $display("[TB] FAIL rstmid_data got %h/%h expected 000/0000", ram_addr, rdata);
        end
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        set_core(0, 1'b1, 9'h011, 16'h0011);
        set_core(3, 1'b1, 9'h013, 16'h0013);
        req = 4'b1001;
        wait_ack(a, d, lat);
        nVectors++;
        if (a !== 4'b0001) begin nMiscompares++; $display("[TB] FAIL rstmid_ptr_cleared got %b expected 0001", a); end
        req[0] = 1'b0;
        wait_ack(a, d, lat);
        nVectors++;
        if (a !== 4'b1000) begin nMiscompares++; $display("[TB] FAIL rstmid_next got %b expected 1000", a); end
        req[3] = 1'b0;
        tick();
    endtask

    task automatic test_boundary;
        logic [3:0]  a;
        logic [15:0] d;
        int          lat;
        do_access(1, 1'b1, 9'h000, 16'h0001, a, d, lat);
        nVectors++;
        if (a !== 4'b0010 || lat != 2) begin
            nMiscompares++;
            $display("[TB] FAIL bnd_wr_low got ack=%b lat=%0d expected 0010 2", a, lat);
        end
        do_access(1, 1'b1, 9'h1FF, 16'hFFFF, a, d, lat);
        do_access(1, 1'b0, 9'h000, 16'h0000, a, d, lat);
        nVectors++;
        if (d !== 16'h0001) begin nMiscompares++; $display("[TB] FAIL bnd_rd_low got %h expected 0001", d); end
        do_access(1, 1'b0, 9'h1FF, 16'h0000, a, d, lat);
        nVectors++;
        if (d !== 16'hFFFF || a !== 4'b0010) begin
            nMiscompares++;
            $display("[TB] FAIL bnd_rd_high got %h ack=%b expected ffff 0010", d, a);
        end
        do_access(1, 1'b1, 9'h100, 16'h5555, a, d, lat);
        nVectors++;
        if (rdata !== 16'hFFFF) begin nMiscompares++; $display("[TB] FAIL bnd_rdata_hold got %h expected ffff", rdata); end
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        rst          = 1'b1;
        req          = '0;
        we           = '0;
        addr         = '0;
        wdata        = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_wrap();
        test_reset_mid_access();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter N_CORES, default 4, number of requesting cores (2..8).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req  input  N_CORES  per-core access request; held until that core's ack.
REQ-005 we  input  N_CORES  per-core op select: 1 write, 0 read; valid while req high.
REQ-006 addr  input  N_CORES*9  per-core word address, core i at bits [9i+8:9i].
REQ-007 wdata  input  N_CORES*16  per-core write data, core i at bits [16i+15:16i].
REQ-008 ack  output  N_CORES  one-cycle completion pulse to the granted core.
REQ-009 rdata  output  16  read result, shared by all cores, valid while ack high.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 ram_write_en, ram_read_en  output  1 each  drive the 512x16 single-port RAM enables.
REQ-012 ram_addr  output  9  RAM address; ram_wdata  output  16  RAM write data.
REQ-013 ram_rdata  input  16  RAM read port; valid the cycle after ram_read_en is sampled.

Function
REQ-014 FSM states IDLE, ACCESS, RDWAIT, DONE; all outputs registered.
REQ-015 IDLE: if any req bit high, pick winner round-robin, latch winner index, we, addr and wdata into ram_* registers, assert exactly one RAM enable, go ACCESS.
REQ-016 ACCESS: hold ram_* registers for exactly one cycle; the RAM acts on the ending edge; clear enables; go DONE if write, RDWAIT if read.
REQ-017 RDWAIT: capture ram_rdata into rdata; go DONE.
REQ-018 DONE: ack[winner] high for exactly this cycle; go IDLE.
REQ-019 Latency from the edge sampling req in IDLE to ack high: write 2 cycles, read 3 cycles; issue-to-issue throughput is one access per 3 (write) or 4 (read) cycles.
REQ-020 Round-robin: search starts at rr_ptr and wraps modulo N_CORES; on grant, rr_ptr <= (winner+1) mod N_CORES; rr_ptr reset 0.
REQ-021 Never both RAM enables high; never more than one ack bit high.
REQ-022 Requesters deassert req on the edge where ack is high; req still high in IDLE is a new request.
REQ-023 Request inputs are ignored outside IDLE; newly arriving reqs wait for IDLE.
REQ-024 rdata holds its last captured value until the next RDWAIT; unaffected by writes.
REQ-025 Simultaneous requests from all cores are served in rotation; no core waits more than N_CORES grants.
REQ-026 A single core requesting repeatedly is granted every round while no other core requests.

Reset
REQ-027 On rst: state IDLE, ack 0, rdata 0, busy 0, ram_write_en 0, ram_read_en 0, ram_addr 0, ram_wdata 0, rr_ptr 0, winner 0.
REQ-028 Reset mid-operation aborts the access without ack; an ACCESS write already sampled by the RAM is not undone.

Structure
REQ-029 Package dram_pkg holds ADDR_W=9, DATA_W=16, default N_CORES=4 and the FSM state enum.
REQ-030 Sub-module rr_picker: combinational; inputs req vector and rr_ptr; outputs valid and winner index.
REQ-031 dram_arbiter instantiates rr_picker once and owns the FSM, the pointer and all output registers.

Verification (N_CORES=4, arbiter driving a behavioural 512x16 RAM)
REQ-032 Core 2 writes 0xBEEF to 0x1A5, then reads 0x1A5 -> write ack at +2 cycles, read ack at +3 with rdata 0xBEEF.
REQ-033 All four cores request together from reset -> acks in order 0,1,2,3; then core 0 again if still requesting.
REQ-034 After core 3 grant, cores 0 and 3 request together -> core 0 first (pointer wrapped to 0).
REQ-035 rst pulsed during ACCESS of a read -> no ack, outputs at reset values, next request served normally with rr_ptr 0.
REQ-036 Reads of 0x000 and 0x1FF after writes 0x0001/0xFFFF -> correct data; ram_write_en and ram_read_en never high together.
